snoop_result_pipe: RTL and testbench

//   Parametrised, pipelined snoop-result generator for the L2 cache simulator bench.

---
 rtl/snoop_result_pipe_if.sv | 33 +++
 rtl/snoop_result_pipe.sv | 152 +++++++++++++++
 tb/tb_snoop_result_pipe.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/snoop_result_pipe_if.sv
// Snoop request/response bus between the shared-bus model and the snoop result pipe.
// Statistics outputs and their clear input travel with the bus.
interface snoop_result_pipe_if #(
    parameter int ADDR_W    = 32,
    parameter int NUM_PEERS = 2,
    parameter int CNT_W     = 16
);
    logic                   req_valid;
    logic                   req_ready;
    logic [ADDR_W-1:0]      req_addr;
    logic [7:0]             req_op;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [1:0]             rsp_result;
    logic [2*NUM_PEERS-1:0] rsp_peer_result;
    logic [ADDR_W-1:0]      rsp_addr;
    logic [7:0]             rsp_op;
    logic                   clear_stats;
    logic [CNT_W-1:0]       hit_count;
    logic [CNT_W-1:0]       hitm_count;

    modport master (
        output req_valid, req_addr, req_op, rsp_ready, clear_stats,
        input  req_ready, rsp_valid, rsp_result, rsp_peer_result, rsp_addr, rsp_op,
               hit_count, hitm_count
    );

    modport slave (
        input  req_valid, req_addr, req_op, rsp_ready, clear_stats,
        output req_ready, rsp_valid, rsp_result, rsp_peer_result, rsp_addr, rsp_op,
               hit_count, hitm_count
    );
endinterface

// File: rtl/snoop_result_pipe.sv
// Pipelined snoop-result generator: per-peer nibble decode, fixed-latency pipe,
// credit-guarded show-ahead response FIFO and saturating HIT/HITM counters.
module snoopPeerDecode (
    input  logic [3:0] nibble,
    output logic [1:0] res
);
    always_comb begin
        case (nibble)
            4'h2, 4'h8: res = 2'b01;
            4'h4, 4'hC: res = 2'b10;
            default:    res = 2'b00;
        endcase
    end
endmodule

module snoop_result_pipe #(
    parameter int ADDR_W     = 32,
    parameter int NUM_PEERS  = 2,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input logic                clk,
    input logic                rst_n,
    snoop_result_pipe_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [1:0]             result;
        logic [2*NUM_PEERS-1:0] peerRes;
        logic [ADDR_W-1:0]      addr;
        logic [7:0]             op;
    } entry_t;

    logic [NUM_PEERS-1:0][3:0] nibbles;
    logic [NUM_PEERS-1:0][1:0] peerDec;
    logic                      anyHit, anyHitm;
    entry_t                    decIn;

    assign nibbles = bus.req_addr[4*NUM_PEERS-1:0];

    snoopPeerDecode uDec [NUM_PEERS-1:0] (.nibble(nibbles), .res(peerDec));

    always_comb begin
        anyHit  = 1'b0;
        anyHitm = 1'b0;
        for (int i = 0; i < NUM_PEERS; i++) begin
            anyHit  = anyHit  | peerDec[i][0];
            anyHitm = anyHitm | peerDec[i][1];
        end
        decIn.result  = anyHitm ? 2'b10 : (anyHit ? 2'b01 : 2'b00);
        decIn.peerRes = peerDec;
        decIn.addr    = bus.req_addr;
        decIn.op      = bus.req_op;
    end

    // Credits cover both in-flight pipe entries and FIFO contents, so a push never finds the FIFO full.
    logic             readyEn;
    logic [OCC_W-1:0] occ;
    logic             accept, pop, push;

    assign bus.req_ready = readyEn && (occ < DEPTH_C);
    assign accept        = bus.req_valid && bus.req_ready;
    assign pop           = bus.rsp_valid && bus.rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readyEn <= 1'b0;
            occ     <= '0;
        end else begin
            readyEn <= 1'b1;
            if (accept && !pop)
                occ <= occ + OCC_W'(1);
            else if (!accept && pop)
                occ <= occ - OCC_W'(1);
        end
    end

    logic [LATENCY:1] vldPipe;
    entry_t           stData [1:LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vldPipe <= '0;
            for (int s = 1; s <= LATENCY; s++) stData[s] <= '0;
        end else begin
            vldPipe[1] <= accept;
            stData[1]  <= decIn;
            for (int s = 2; s <= LATENCY; s++) begin
                vldPipe[s] <= vldPipe[s-1];
                stData[s]  <= stData[s-1];
            end
        end
    end

    assign push = vldPipe[LATENCY];

    entry_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [OCC_W-1:0] fifoCnt;
    entry_t           head;

    assign head                = mem[rdPtr];
    assign bus.rsp_valid       = (fifoCnt != '0);
    assign bus.rsp_result      = head.result;
    assign bus.rsp_peer_result = head.peerRes;
    assign bus.rsp_addr        = head.addr;
    assign bus.rsp_op          = head.op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            fifoCnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wrPtr] <= stData[LATENCY];
                wrPtr      <= wrPtr + PTR_W'(1);
            end
            if (pop)
                rdPtr <= rdPtr + PTR_W'(1);
            if (push && !pop)
                fifoCnt <= fifoCnt + OCC_W'(1);
            else if (!push && pop)
                fifoCnt <= fifoCnt - OCC_W'(1);
        end
    end

    logic [CNT_W-1:0] hitCnt, hitmCnt;

    assign bus.hit_count  = hitCnt;
    assign bus.hitm_count = hitmCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hitCnt  <= '0;
            hitmCnt <= '0;
        end else if (bus.clear_stats) begin
            hitCnt  <= '0;
            hitmCnt <= '0;
        end else if (pop) begin
            if (head.result == 2'b01 && hitCnt != '1)
                hitCnt <= hitCnt + CNT_W'(1);
            if (head.result == 2'b10 && hitmCnt != '1)
                hitmCnt <= hitmCnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_snoop_result_pipe.sv
// Directed bench for snoop_result_pipe: decode table, latency, backpressure, wrap,
// counter saturation/clear and asynchronous reset.
module tb_snoop_result_pipe;
    localparam int AW = 32, NP = 2, LAT = 2, FD = 4, CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    snoop_result_pipe_if #(.ADDR_W(AW), .NUM_PEERS(NP), .CNT_W(CW)) bus ();

    snoop_result_pipe #(
        .ADDR_W(AW), .NUM_PEERS(NP), .LATENCY(LAT), .FIFO_DEPTH(FD), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  op;
        logic [3:0]  peer;
        logic [1:0]  res;
    } vec_t;

    typedef struct {
        logic [1:0]  res;
        logic [3:0]  peer;
        logic [31:0] addr;
        logic [7:0]  op;
        int          t;
    } obs_t;

    int          total = 0, bad = 0, cyc = 0;
    obs_t        obsQ[$];
    logic [39:0] accQ[$];
    vec_t        vecs[9];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            obsQ.delete();
            accQ.delete();
        end else begin
            if (bus.req_valid && bus.req_ready) accQ.push_back({bus.req_op, bus.req_addr});
            if (bus.rsp_valid && bus.rsp_ready)
                obsQ.push_back('{bus.rsp_result, bus.rsp_peer_result, bus.rsp_addr, bus.rsp_op, cyc});
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference decode used only for scoreboarded streams; the table uses hand values.
    function automatic logic [1:0] refRes(input logic [31:0] a);
        logic hit, hitm;
        hit = 1'b0; hitm = 1'b0;
        for (int i = 0; i < NP; i++) begin
            logic [31:0] sh;
            sh = a >> (4 * i);
            if (sh[3:0] == 4'h2 || sh[3:0] == 4'h8) hit = 1'b1;
            if (sh[3:0] == 4'h4 || sh[3:0] == 4'hC) hitm = 1'b1;
        end
        return hitm ? 2'b10 : (hit ? 2'b01 : 2'b00);
    endfunction

    task automatic chkResetOutputs(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_result"}, bus.rsp_result, 0);
        chk({tag, "_rsp_peer"}, bus.rsp_peer_result, 0);
        chk({tag, "_rsp_addr"}, bus.rsp_addr, 0);
        chk({tag, "_rsp_op"}, bus.rsp_op, 0);
        chk({tag, "_hit_count"}, bus.hit_count, 0);
        chk({tag, "_hitm_count"}, bus.hitm_count, 0);
    endtask

    // One isolated request with rsp_ready=1: checks the response appears exactly LAT edges later.
    task automatic sendOne(input string tag, input vec_t v);
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_addr = v.addr; bus.req_op = v.op;
        @(negedge clk) chk({tag, "_ready"}, bus.req_ready, 1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk) chk({tag, "_early0"}, bus.rsp_valid, 0);
        for (int k = 1; k < LAT; k++) begin
            @(posedge clk);
            @(negedge clk) chk($sformatf("%s_early%0d", tag, k), bus.rsp_valid, 0);
        end
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_valid"}, bus.rsp_valid, 1);
        chk({tag, "_result"}, bus.rsp_result, v.res);
        chk({tag, "_peer"}, bus.rsp_peer_result, v.peer);
        chk({tag, "_addr"}, bus.rsp_addr, v.addr);
        chk({tag, "_op"}, bus.rsp_op, v.op);
    endtask

    task automatic pulseClear();
        @(posedge clk); #1 bus.clear_stats = 1'b1;
        @(posedge clk); #1 bus.clear_stats = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int expHit, expHitm, rdyCycles, vldCycles;
        logic [31:0] a;

        vecs[0] = '{32'h0000_0042, 8'h01, 4'b1001, 2'b10};
        vecs[1] = '{32'h0000_0002, 8'h11, 4'b0001, 2'b01};
        vecs[2] = '{32'h0000_000C, 8'h22, 4'b0010, 2'b10};
        vecs[3] = '{32'h0000_0005, 8'h33, 4'b0000, 2'b00};
        vecs[4] = '{32'h0000_0080, 8'h44, 4'b0100, 2'b01};
        vecs[5] = '{32'h0000_00CC, 8'h55, 4'b1010, 2'b10};
        vecs[6] = '{32'h0000_0028, 8'h66, 4'b0101, 2'b01};
        vecs[7] = '{32'h0000_00FF, 8'h77, 4'b0000, 2'b00};
        vecs[8] = '{32'hABCD_0012, 8'hA5, 4'b0001, 2'b01};

        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_op = '0;
        bus.rsp_ready = 1'b1; bus.clear_stats = 1'b0;

        #1 rst_n = 1'b0;
        #2 chkResetOutputs("por");
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk) chk("ready_before_edge", bus.req_ready, 0);
        @(posedge clk);
        @(negedge clk) chk("ready_after_edge", bus.req_ready, 1);

        // Decode table, one request at a time
        expHit = 0; expHitm = 0;
        foreach (vecs[i]) begin
            sendOne($sformatf("vec%0d", i), vecs[i]);
            if (vecs[i].res == 2'b01) expHit++;
            if (vecs[i].res == 2'b10) expHitm++;
        end
        idle(1);
        @(negedge clk);
        chk("table_hit_count", bus.hit_count, expHit);
        chk("table_hitm_count", bus.hitm_count, expHitm);

        // Back-to-back stream; 0x80 decodes HIT through peer1 nibble 8
        pulseClear();
        @(negedge clk) chk("clear_hit", bus.hit_count, 0);
        chk("clear_hitm", bus.hitm_count, 0);
        @(posedge clk); #1;
        obsQ.delete();
        bus.req_valid = 1'b1;
        foreach (vecs[i]) begin end
        bus.req_addr = 32'h02; @(posedge clk); #1;
        bus.req_addr = 32'h0C; @(posedge clk); #1;
        bus.req_addr = 32'h05; @(posedge clk); #1;
        bus.req_addr = 32'h80; @(posedge clk); #1;
        bus.req_valid = 1'b0;
        idle(6);
        chk("b2b_count", obsQ.size(), 4);
        if (obsQ.size() == 4) begin
            chk("b2b_res0", obsQ[0].res, 2'b01);
            chk("b2b_res1", obsQ[1].res, 2'b10);
            chk("b2b_res2", obsQ[2].res, 2'b00);
            chk("b2b_res3", obsQ[3].res, 2'b01);
            chk("b2b_addr3", obsQ[3].addr, 32'h80);
            chk("b2b_spacing", obsQ[3].t - obsQ[0].t, 3);
        end
        @(negedge clk);
        chk("b2b_hit_count", bus.hit_count, 2);
        chk("b2b_hitm_count", bus.hitm_count, 1);

        // Backpressure: exactly FD accepted while rsp_ready=0
        @(posedge clk); #1;
        obsQ.delete(); accQ.delete();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.req_addr = (k << 4) | 32'h2; bus.req_op = 8'(k);
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("bp_accepted", accQ.size(), FD);
        chk("bp_ready_low", bus.req_ready, 0);
        chk("bp_no_pops", obsQ.size(), 0);
        @(posedge clk); #1 bus.rsp_ready = 1'b1;
        @(posedge clk); #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_ready_back", bus.req_ready, 1);
        chk("bp_one_pop", obsQ.size(), 1);

        // Refill to full, then stream with simultaneous accept and pop across pointer wrap
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_addr = 32'h1C4; bus.req_op = 8'h40;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        rdyCycles = 0;
        for (int k = 0; k < 12; k++) begin
            bus.req_addr = 32'h200 + (k << 4) + (k % 4) * 2; bus.req_op = 8'h80 + 8'(k);
            @(negedge clk) if (bus.req_ready) rdyCycles++;
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        chk("wrap_ready_cycles", rdyCycles, 11);
        idle(10);
        chk("wrap_accepted", accQ.size(), 4 * FD);
        chk("wrap_popped", obsQ.size(), accQ.size());
        if (obsQ.size() == accQ.size()) begin
            int errs;
            errs = 0;
            foreach (accQ[i]) begin
                if (obsQ[i].addr !== accQ[i][31:0] || obsQ[i].op !== accQ[i][39:32] ||
                    obsQ[i].res !== refRes(accQ[i][31:0]))
                    errs++;
            end
            chk("wrap_order_data", errs, 0);
        end

        // Saturation of a 4-bit HITM counter, then clear against a coincident pop
        pulseClear();
        bus.req_valid = 1'b1; bus.req_addr = 32'h04; bus.req_op = 8'hEE;
        repeat (15) @(posedge clk);
        #1 bus.req_valid = 1'b0;
        idle(5);
        @(negedge clk) chk("sat_at_15", bus.hitm_count, 4'hF);
        sendOne("sat_extra", '{32'h04, 8'hEE, 4'b0010, 2'b10});
        idle(2);
        @(negedge clk);
        chk("sat_hold", bus.hitm_count, 4'hF);
        chk("sat_hit_zero", bus.hit_count, 0);
        bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus.req_valid = 1'b0;
        idle(4);
        @(posedge clk); #1 bus.rsp_ready = 1'b1; bus.clear_stats = 1'b1;
        @(posedge clk); #1 bus.rsp_ready = 1'b0; bus.clear_stats = 1'b0;
        @(negedge clk) chk("clear_vs_pop", bus.hitm_count, 0);
        @(posedge clk); #1 bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk) chk("count_after_clear", bus.hitm_count, 1);

        // Asynchronous reset with requests in flight
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_addr = 32'h42; bus.req_op = 8'h5A;
        repeat (3) @(posedge clk);
        #1 bus.req_valid = 1'b0;
        rst_n = 1'b0;
        #1 chkResetOutputs("async");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk) chk("rel_ready_before_edge", bus.req_ready, 0);
        bus.rsp_ready = 1'b1;
        vldCycles = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk) if (bus.rsp_valid) vldCycles++;
        end
        chk("no_stale_rsp", vldCycles, 0);
        sendOne("post_reset", '{32'h0000_000C, 8'h3C, 4'b0010, 2'b10});
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
